// File: rtl/aula_201029_qsys_pio_poller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aula_pio_pkg                                                 |
// | Description : Shared types and constants for the Avalon PIO poller.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package aula_pio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  localparam logic [31:0] PIO_DATA_OFFSET = 'd0;
  localparam int          AVM_DATA_W      = 32;

  // Bit width needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : aula_pio_pkg
`default_nettype wire

// File: rtl/aula_201029_qsys_pio_poller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : aula_201029_qsys_pio_poller_if                               |
// | Description : Avalon-MM read-only master/slave signal bundle.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface aula_201029_qsys_pio_poller_if
  import aula_pio_pkg::*;
#(
  parameter int ADDR_W = 2
);

  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [AVM_DATA_W-1:0] avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface : aula_201029_qsys_pio_poller_if
`default_nettype wire

// File: rtl/aula_201029_qsys_pio_poller_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pio_poll_debounce                                            |
// | Description : Candidate/count debouncer deciding when a capture commits.   |
// |               Present only when PIO_POLLER_DEBOUNCE_EN is defined.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`ifdef PIO_POLLER_DEBOUNCE_EN
module pio_poll_debounce
  import aula_pio_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEB_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture_valid,
  input  logic [DATA_W-1:0] i_capture,
  input  logic [DATA_W-1:0] i_sample_data,
  input  logic              i_first_flag,
  output logic              o_commit
);

  localparam int              CNT_W     = cnt_width(DEB_CNT);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_CNT);

  logic [DATA_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_match;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_match    = (i_capture == r_cand);
  assign w_cnt_next = !w_match            ? CNT_W'(1) :
                      (r_cnt == c_cnt_max) ? r_cnt     : r_cnt + 1'b1;

  // The very first stable value commits even if it equals the reset value.
  assign o_commit = i_capture_valid && (w_cnt_next == c_cnt_max) &&
                    ((i_capture != i_sample_data) || i_first_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (i_capture_valid) begin
      r_cand <= i_capture;
      r_cnt  <= w_cnt_next;
    end
  end

endmodule : pio_poll_debounce
`endif
`default_nettype wire

// File: rtl/aula_201029_qsys_pio_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aula_201029_qsys_pio_poller                                  |
// | Description : Avalon-MM master polling a PIO data register at a fixed      |
// |               rate. Optional debounce via PIO_POLLER_DEBOUNCE_EN.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module aula_201029_qsys_pio_poller
  import aula_pio_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int POLL_DIV = 50000,
  parameter int TIMEOUT  = 255,
  parameter int DEB_CNT  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  aula_201029_qsys_pio_poller_if.master avm,
  output logic [DATA_W-1:0]            sample_data,
  output logic                         sample_valid,
  output logic                         sample_changed,
  output logic                         timeout_err
);

  localparam int               DIV_W        = cnt_width(POLL_DIV - 1);
  localparam int               TO_W         = cnt_width(TIMEOUT);
  localparam logic [DIV_W-1:0] c_div_reload = DIV_W'(POLL_DIV - 1);
  localparam logic [TO_W-1:0]  c_to_last    = TO_W'(TIMEOUT - 1);

  poll_state_t       r_state;
  logic [DIV_W-1:0]  r_div;
  logic [TO_W-1:0]   r_to;
  logic              r_first;

  logic [DATA_W-1:0] w_capture;
  logic              w_take;
  logic              w_commit;
  logic              w_changed;

  assign w_capture = avm.avm_readdata[DATA_W-1:0];
  assign w_take    = (r_state == WAIT) && avm.avm_readdatavalid;

  generate
    if (DATA_W < AVM_DATA_W) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^avm.avm_readdata[AVM_DATA_W-1:DATA_W];
    end
  endgenerate

`ifdef PIO_POLLER_DEBOUNCE_EN
  pio_poll_debounce #(
    .DATA_W  (DATA_W),
    .DEB_CNT (DEB_CNT)
  ) u_debounce (
    .clk             (clk),
    .rst             (reset),
    .i_capture_valid (w_take),
    .i_capture       (w_capture),
    .i_sample_data   (sample_data),
    .i_first_flag    (r_first),
    .o_commit        (w_commit)
  );
  assign w_changed = w_commit;
`else
  localparam int c_unused_deb = DEB_CNT;
  assign w_commit  = 1'b1;
  assign w_changed = (w_capture != sample_data) || r_first;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_div           <= c_div_reload;
      r_to            <= '0;
      r_first         <= 1'b1;
      sample_data     <= '0;
      sample_valid    <= 1'b0;
      sample_changed  <= 1'b0;
      timeout_err     <= 1'b0;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= '0;
    end else begin
      sample_valid    <= 1'b0;
      sample_changed  <= 1'b0;
      timeout_err     <= 1'b0;
      avm.avm_address <= ADDR_W'(PIO_DATA_OFFSET);
      case (r_state)
        IDLE: begin
          if (!enable) begin
            r_div <= c_div_reload;
          end else if (r_div == '0) begin
            r_state      <= REQ;
            avm.avm_read <= 1'b1;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        // No timeout while stalled: Avalon does not allow withdrawing a read.
        REQ: begin
          if (!avm.avm_waitrequest) begin
            r_state      <= WAIT;
            avm.avm_read <= 1'b0;
            r_to         <= '0;
          end
        end
        WAIT: begin
          if (avm.avm_readdatavalid) begin
            sample_valid   <= 1'b1;
            sample_changed <= w_changed;
            if (w_commit) begin
              sample_data <= w_capture;
              r_first     <= 1'b0;
            end
            r_state <= IDLE;
            r_div   <= c_div_reload;
          end else if (r_to == c_to_last) begin
            timeout_err <= 1'b1;
            r_state     <= IDLE;
            r_div       <= c_div_reload;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          avm.avm_read <= 1'b0;
          r_div        <= c_div_reload;
        end
      endcase
    end
  end

endmodule : aula_201029_qsys_pio_poller
`default_nettype wire
